// File: rtl/spi_slv_bridge.sv
// Purpose: SPI mode-0 slave that turns control-word transactions into single-cycle CSR bus reads/writes (build option SPI_SLV_ABORT_CNT_EN adds abort_cnt).
// Latency: SPI pins pass a 3-clk sync/edge stage; bus_wen 1 clk after the last data bit's sck_rise, bus_ren 1 clk after the last control bit.
// Backpressure: none; the bus accepts every strobe, and clk must be >= 8x sck so that read data reaches miso before the master samples it.
module spi_slv_bridge #(
  parameter int LEN_W  = 14,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_wen,
  output logic              bus_ren,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy
`ifdef SPI_SLV_ABORT_CNT_EN
  ,
  output logic [7:0]        abort_cnt
`endif
);

  localparam int CTRL_W = 2 + LEN_W + ADDR_W;
  localparam int RX_W   = (CTRL_W > DATA_W) ? CTRL_W : DATA_W;
  localparam int CNT_W  = $clog2(RX_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_WR_DATA,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // [0],[1] are the 2-FF synchroniser, [2] is the edge-detect register
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [2:0] mosi_q;

  logic sck_rise;
  logic sck_fall;
  logic cs_rise;
  logic cs_fall;
  logic mosi_b;

  // Receive shifter keeps all but the newest bit; the newest comes straight from mosi_b
  logic [RX_W-2:0]   rx_sh;
  // Transmit shifter holds the bits still to go after the one currently on miso
  logic [DATA_W-2:0] tx_sh;
  logic [DATA_W-1:0] rd_buf;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic              incr;
  logic              ta;       // turnaround rise of a read not yet seen
  logic              sampled;  // a data bit was taken by the master since the last miso update
  logic              ren_d;    // bus_rdata is valid this clk

  logic [CTRL_W-1:0] ctrl_word;
  logic [DATA_W-1:0] wr_word;
  logic              ctrl_last;
  logic              wr_last;
  logic              rd_last;
  logic              wr_fire;
  logic              rd_fire;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_b   = mosi_q[2];

  assign ctrl_word = {rx_sh[CTRL_W-2:0], mosi_b};
  assign wr_word   = {rx_sh[DATA_W-2:0], mosi_b};

  assign ctrl_last = (state == S_CTRL) && sck_rise && (bit_cnt == CNT_W'(CTRL_W - 1));
  assign wr_last   = (state == S_WR_DATA) && sck_rise && (bit_cnt == CNT_W'(DATA_W - 1));
  assign rd_last   = (state == S_RD_DATA) && sck_rise && !ta && (bit_cnt == CNT_W'(DATA_W - 1));

  // Pin synchronisers; cs resets "low" so a chip select already asserted across reset never looks like a new start
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q  <= '0;
      cs_q   <= '0;
      mosi_q <= '0;
    end else begin
      sck_q  <= {sck_q[1:0], spi_sck};
      cs_q   <= {cs_q[1:0], spi_cs_n};
      mosi_q <= {mosi_q[1:0], spi_mosi};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus strobe requests; cs_n rising outranks everything, including a same-clk last bit
  always_comb begin
    state_nxt = state;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    if (state != S_IDLE && cs_rise) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (cs_fall) state_nxt = S_CTRL;
        S_CTRL: begin
          if (ctrl_last) begin
            state_nxt = ctrl_word[CTRL_W-1] ? S_WR_DATA : S_RD_DATA;
            rd_fire   = ~ctrl_word[CTRL_W-1];
          end
        end
        S_WR_DATA: begin
          if (wr_last) begin
            wr_fire = 1'b1;
            if (word_cnt == '0) state_nxt = S_DONE;
          end
        end
        S_RD_DATA: begin
          if (rd_last) begin
            if (word_cnt == '0) state_nxt = S_DONE;
            else                rd_fire   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath: shifters, counters, bus address/data and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_miso  <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wen   <= 1'b0;
      bus_ren   <= 1'b0;
      busy      <= 1'b0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      rd_buf    <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      incr      <= 1'b0;
      ta        <= 1'b0;
      sampled   <= 1'b0;
      ren_d     <= 1'b0;
    end else begin
      bus_wen <= wr_fire;
      bus_ren <= rd_fire;
      ren_d   <= bus_ren;
      busy    <= (state_nxt != S_IDLE);
      // Write address advances the clk after its strobe
      if (bus_wen) bus_addr <= bus_addr + ADDR_W'(incr);

      if (state != S_IDLE && cs_rise) begin
        spi_miso <= 1'b0;
        bit_cnt  <= '0;
        sampled  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            spi_miso <= 1'b0;
            bit_cnt  <= '0;
            sampled  <= 1'b0;
            ta       <= 1'b1;
          end
          S_CTRL: begin
            if (sck_rise) begin
              rx_sh   <= {rx_sh[RX_W-3:0], mosi_b};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (ctrl_last) begin
              bit_cnt  <= '0;
              incr     <= ctrl_word[CTRL_W-2];
              word_cnt <= ctrl_word[ADDR_W +: LEN_W];
              bus_addr <= ctrl_word[ADDR_W-1:0];
            end
          end
          S_WR_DATA: begin
            if (sck_rise) begin
              rx_sh   <= {rx_sh[RX_W-3:0], mosi_b};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (wr_last) begin
              bit_cnt   <= '0;
              bus_wdata <= wr_word;
              if (word_cnt != '0) word_cnt <= word_cnt - LEN_W'(1);
            end
          end
          S_RD_DATA: begin
            // First word goes straight to miso; later words wait in rd_buf for the word-ending fall
            if (ren_d) begin
              if (!sampled) begin
                spi_miso <= bus_rdata[DATA_W-1];
                tx_sh    <= bus_rdata[DATA_W-2:0];
              end else begin
                rd_buf <= bus_rdata;
              end
            end
            if (sck_rise) begin
              if (ta) begin
                ta <= 1'b0;
              end else begin
                sampled <= 1'b1;
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (rd_last) begin
                  bit_cnt <= '0;
                  if (word_cnt != '0) begin
                    word_cnt <= word_cnt - LEN_W'(1);
                    bus_addr <= bus_addr + ADDR_W'(incr);
                  end
                end
              end
            end
            if (sck_fall && sampled) begin
              sampled <= 1'b0;
              if (bit_cnt == '0) begin
                spi_miso <= rd_buf[DATA_W-1];
                tx_sh    <= rd_buf[DATA_W-2:0];
              end else begin
                spi_miso <= tx_sh[DATA_W-2];
                tx_sh    <= {tx_sh[DATA_W-3:0], 1'b0};
              end
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

`ifdef SPI_SLV_ABORT_CNT_EN
  logic abort;
  assign abort = cs_rise && (state != S_IDLE) && (state != S_DONE);

  // Saturating count of transactions cut short by cs_n
  always_ff @(posedge clk) begin
    if (rst)                               abort_cnt <= '0;
    else if (abort && abort_cnt != 8'hFF)  abort_cnt <= abort_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_spi_slv_bridge.sv
// Purpose: scoreboard bench for spi_slv_bridge driving an SPI mode-0 master model and a CSR memory model.
// Latency: 32 MHz clk, 4 MHz sck; expected writes/reads are queued at stimulus time and popped as the DUT produces them.
// Backpressure: none; the memory model answers every bus_ren one clk later with addr*0x0101.
`timescale 1ns/1ps
module tb_spi_slv_bridge;

  localparam real TCLK_H = 15.625;
  localparam real SCK_H  = 125.0;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_sck;
  logic        spi_cs_n;
  logic        spi_mosi;
  logic        spi_miso;
  logic [7:0]  bus_addr;
  logic [15:0] bus_wdata;
  logic        bus_wen;
  logic        bus_ren;
  logic [15:0] bus_rdata;
  logic        busy;
`ifdef SPI_SLV_ABORT_CNT_EN
  logic [7:0]  abort_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;

  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];

  spi_slv_bridge #(.LEN_W(14), .DATA_W(16), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wen   (bus_wen),
    .bus_ren   (bus_ren),
    .bus_rdata (bus_rdata),
    .busy      (busy)
`ifdef SPI_SLV_ABORT_CNT_EN
    ,
    .abort_cnt (abort_cnt)
`endif
  );

  always #(TCLK_H) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CSR memory model: read data is addr*0x0101, valid the clk after bus_ren
  always @(posedge clk) begin
    if (rst)          bus_rdata <= '0;
    else if (bus_ren) bus_rdata <= {bus_addr, bus_addr};
  end

  // Bus monitor: strobe exclusivity, strobe counts and write scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_wen || bus_ren) chk("wen_ren_excl", {31'd0, bus_wen & bus_ren}, 32'd0);
      if (bus_ren) ren_cnt++;
      if (bus_wen) begin
        wen_cnt++;
        chk("wr_expected", {31'd0, exp_wr.size() != 0}, 32'd1);
        if (exp_wr.size() != 0) begin
          logic [23:0] e;
          e = exp_wr.pop_front();
          chk("wr_addr", {24'd0, bus_addr}, {24'd0, e[23:16]});
          chk("wr_data", {16'd0, bus_wdata}, {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic sync_clk();
    @(posedge clk);
    #7;
  endtask

  task automatic sck_bit(input logic mo, output logic mi);
    spi_mosi = mo;
    #(SCK_H);
    spi_sck = 1'b1;
    mi = spi_miso;
    #(SCK_H);
    spi_sck = 1'b0;
  endtask

  task automatic spi_start(input logic rw, input logic inc, input logic [13:0] len, input logic [7:0] addr);
    logic [23:0] c;
    logic d;
    c = {rw, inc, len, addr};
    spi_cs_n = 1'b0;
    #(SCK_H);
    for (int i = 23; i >= 0; i--) sck_bit(c[i], d);
  endtask

  task automatic wr_bits(input logic [15:0] w, input int nbits);
    logic d;
    for (int i = 15; i >= 16 - nbits; i--) sck_bit(w[i], d);
  endtask

  task automatic rd_bits(input int nbits, output logic [15:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < nbits; i++) begin
      sck_bit(1'b0, b);
      w = {w[14:0], b};
    end
  endtask

  task automatic rd_turnaround();
    logic d;
    sck_bit(1'b0, d);
  endtask

  task automatic rd_check(input int nwords);
    logic [15:0] w;
    for (int k = 0; k < nwords; k++) begin
      rd_bits(16, w);
      chk("rd_expected", {31'd0, exp_rd.size() != 0}, 32'd1);
      if (exp_rd.size() != 0) chk("rd_data", {16'd0, w}, {16'd0, exp_rd.pop_front()});
    end
  endtask

  task automatic spi_stop(input real gap);
    #(SCK_H);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    #(gap);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    int r0;
    logic [15:0] part;

    rst = 1'b1;
    spi_sck = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_addr", {24'd0, bus_addr}, 32'd0);
    chk("rst_wdata", {16'd0, bus_wdata}, 32'd0);
    chk("rst_wen", {31'd0, bus_wen}, 32'd0);
    chk("rst_ren", {31'd0, bus_ren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLV_ABORT_CNT_EN
    chk("rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Incrementing write burst
    w0 = wen_cnt; r0 = ren_cnt;
    exp_wr.push_back({8'h10, 16'h1234});
    exp_wr.push_back({8'h11, 16'hABCD});
    exp_wr.push_back({8'h12, 16'h0F0F});
    sync_clk();
    spi_start(1'b1, 1'b1, 14'd2, 8'h10);
    wr_bits(16'h1234, 16);
    chk("wr_busy_mid", {31'd0, busy}, 32'd1);
    wr_bits(16'hABCD, 16);
    wr_bits(16'h0F0F, 16);
    spi_stop(2 * SCK_H);
    repeat (4) @(negedge clk);
    chk("wr_busy_end", {31'd0, busy}, 32'd0);
    chk("wr_incr_cnt", wen_cnt - w0, 32'd3);
    chk("wr_incr_ren", ren_cnt - r0, 32'd0);

    // Fixed-address write at top of map
    w0 = wen_cnt;
    exp_wr.push_back({8'hFE, 16'hAAAA});
    exp_wr.push_back({8'hFE, 16'h5555});
    sync_clk();
    spi_start(1'b1, 1'b0, 14'd1, 8'hFE);
    wr_bits(16'hAAAA, 16);
    wr_bits(16'h5555, 16);
    spi_stop(2 * SCK_H);
    chk("wr_fixed_cnt", wen_cnt - w0, 32'd2);

    // Incrementing read that wraps the address
    w0 = wen_cnt; r0 = ren_cnt;
    exp_rd.push_back(16'hFEFE);
    exp_rd.push_back(16'hFFFF);
    exp_rd.push_back(16'h0000);
    exp_rd.push_back(16'h0101);
    sync_clk();
    spi_start(1'b0, 1'b1, 14'd3, 8'hFE);
    rd_turnaround();
    rd_check(4);
    chk("rd_done_miso", {31'd0, spi_miso}, 32'd0);
    spi_stop(2 * SCK_H);
    chk("rd_ren_cnt", ren_cnt - r0, 32'd4);
    chk("rd_wen_cnt", wen_cnt - w0, 32'd0);
    chk("rd_busy_end", {31'd0, busy}, 32'd0);

    // Write aborted halfway through its only word
    w0 = wen_cnt;
    sync_clk();
    spi_start(1'b1, 1'b1, 14'd0, 8'h33);
    wr_bits(16'hC3C3, 8);
    spi_stop(2 * SCK_H);
    chk("abort_wen", wen_cnt - w0, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
`ifdef SPI_SLV_ABORT_CNT_EN
    chk("abort_cnt", {24'd0, abort_cnt}, 32'd1);
`endif

    // Reset during a read's data phase, then a fresh write
    sync_clk();
    spi_start(1'b0, 1'b1, 14'd1, 8'h30);
    rd_turnaround();
    rd_bits(8, part);
    chk("rst_rd_byte", {24'd0, part[7:0]}, 32'h30);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_miso", {31'd0, spi_miso}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {24'd0, bus_addr}, 32'd0);
    w0 = wen_cnt; r0 = ren_cnt;
    #3;
    rd_bits(8, part);
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
    chk("midrst_idle_miso", {31'd0, spi_miso}, 32'd0);
    spi_stop(2 * SCK_H);
    exp_wr.push_back({8'h20, 16'hBEEF});
    sync_clk();
    spi_start(1'b1, 1'b1, 14'd0, 8'h20);
    wr_bits(16'hBEEF, 16);
    spi_stop(2 * SCK_H);
    chk("postrst_wen", wen_cnt - w0, 32'd1);
    chk("postrst_ren", ren_cnt - r0, 32'd0);

    // Back-to-back read then write with one idle clk of cs_n high
    w0 = wen_cnt; r0 = ren_cnt;
    exp_rd.push_back(16'h4040);
    exp_rd.push_back(16'h4141);
    exp_wr.push_back({8'h50, 16'h1357});
    sync_clk();
    spi_start(1'b0, 1'b1, 14'd1, 8'h40);
    rd_turnaround();
    rd_check(2);
    spi_stop(2 * TCLK_H);
    spi_start(1'b1, 1'b1, 14'd0, 8'h50);
    wr_bits(16'h1357, 16);
    spi_stop(2 * SCK_H);
    chk("b2b_ren", ren_cnt - r0, 32'd2);
    chk("b2b_wen", wen_cnt - w0, 32'd1);
    chk("b2b_busy", {31'd0, busy}, 32'd0);

    repeat (8) @(negedge clk);
    chk("wr_q_left", exp_wr.size(), 32'd0);
    chk("rd_q_left", exp_rd.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
